sig_eth_udp_packer: RTL and testbench

- Downstream of the signal-select stage; drains the 32-bit SIG-ETHERNET FIFO read side.
- Frames fixed-size blocks of captured words (AD/HDMI) into UDP payloads, each with an 8-byte header.
- Streams each payload byte-wise into the UDP transmit interface of the ethernet stack.
- Runs entirely in the ethernet transmit clock domain.

---
 rtl/sig_eth_udp_packer_pkg.sv | 35 +++
 rtl/sig_eth_word_serializer.sv | 42 ++++
 rtl/sig_eth_udp_packer.sv | 176 +++++++++++++++++
 tb/tb_sig_eth_udp_packer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_eth_udp_packer_pkg.sv
// rtl/sig_eth_udp_packer_pkg.sv - shared types, constants and header byte mux for the SIG-ETH UDP packer
package sig_eth_udp_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HDR,
        ST_DATA,
        ST_DONE
    } pk_state_e;

    localparam int          HDR_BYTES     = 8;
    localparam logic [1:0]  TAG_AD        = 2'b10;
    localparam logic [1:0]  TAG_HDMI      = 2'b01;
    localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;

    // Header layout: magic, tag, reserved, sequence, payload word count (all big-endian)
    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [15:0] magic,
                                            input logic [1:0]  tag,
                                            input logic [15:0] seq,
                                            input logic [15:0] words);
        case (idx)
            3'd0:    hdr_byte = magic[15:8];
            3'd1:    hdr_byte = magic[7:0];
            3'd2:    hdr_byte = {6'b0, tag};
            3'd3:    hdr_byte = 8'h00;
            3'd4:    hdr_byte = seq[15:8];
            3'd5:    hdr_byte = seq[7:0];
            3'd6:    hdr_byte = words[15:8];
            default: hdr_byte = words[7:0];
        endcase
    endfunction

endpackage

// File: rtl/sig_eth_word_serializer.sv
// rtl/sig_eth_word_serializer.sv - 32->8 MSB-first word shifter with zero fill and read-slot timing
module sig_eth_word_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic        zero_fill,
    input  logic [31:0] word_in,
    output logic [7:0]  byte_nxt,
    output logic        rd_slot,
    output logic        word_end
);

    logic [23:0] sr;
    logic [1:0]  bidx;

    // byte_nxt is the byte the owner registers onto the output this edge
    always_comb begin
        byte_nxt = 8'h00;
        if (!zero_fill) begin
            byte_nxt = load ? word_in[31:24] : sr[23:16];
        end
    end

    // Requesting the next word while byte 2 is on the wire lands it exactly after byte 3
    assign rd_slot  = (bidx == 2'd1);
    assign word_end = (bidx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            bidx <= '0;
        end else if (load) begin
            sr   <= zero_fill ? 24'h0 : word_in[23:0];
            bidx <= 2'd0;
        end else if (shift) begin
            sr   <= zero_fill ? 24'h0 : {sr[15:0], 8'h00};
            bidx <= bidx + 2'd1;
        end
    end

endmodule

// File: rtl/sig_eth_udp_packer.sv
// rtl/sig_eth_udp_packer.sv - frames FIFO words into fixed-length UDP payloads for the ethernet stack
module sig_eth_udp_packer
    import sig_eth_udp_packer_pkg::*;
#(
    parameter int          PAYLOAD_WORDS = 256,
    parameter int          LVL_W         = 12,
    parameter int          ACK_TIMEOUT   = 50000,
    parameter logic [15:0] MAGIC         = MAGIC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       stream_tag,
    input  logic             fifo_flush,
    input  logic [31:0]      fifo_rd_data,
    input  logic [LVL_W-1:0] fifo_rd_level,
    output logic             fifo_rd_en,
    input  logic             udp_tx_ready,
    output logic             app_tx_data_request,
    input  logic             app_tx_ack,
    output logic [15:0]      udp_data_length,
    output logic             app_tx_data_valid,
    output logic [7:0]       app_tx_data,
    output logic [15:0]      frame_seq,
    output logic [15:0]      drop_cnt
);

    localparam int               TO_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [LVL_W:0]   NEED      = (LVL_W + 1)'(PAYLOAD_WORDS);
    localparam logic [11:0]      LAST_WORD = 12'(PAYLOAD_WORDS - 1);
    localparam logic [15:0]      PW16      = 16'(PAYLOAD_WORDS);

    pk_state_e       state, state_n;
    logic [TO_W-1:0] to_cnt, to_n;
    logic [2:0]      hdr_idx, hdr_n;
    logic [11:0]     word_idx, word_n;
    logic [1:0]      tag_r, tag_n;
    logic            flushed_r, flushed_n;
    logic [15:0]     seq_n, drop_n;
    logic            req_n, valid_n, rd_n;
    logic [7:0]      data_n;
    logic            ser_load, ser_shift, ser_rd_slot, ser_word_end;
    logic [7:0]      ser_byte;
    logic            zero, start_ok;

    assign udp_data_length = 16'(HDR_BYTES + 4 * PAYLOAD_WORDS);
    // Once flushed, the frame still runs to its committed length but carries only zeros
    assign zero     = fifo_flush | flushed_r;
    assign start_ok = enable && udp_tx_ready && ({1'b0, fifo_rd_level} >= NEED) && !fifo_flush;

    sig_eth_word_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .shift     (ser_shift),
        .zero_fill (zero),
        .word_in   (fifo_rd_data),
        .byte_nxt  (ser_byte),
        .rd_slot   (ser_rd_slot),
        .word_end  (ser_word_end)
    );

    always_comb begin
        state_n   = state;
        req_n     = 1'b0;
        valid_n   = 1'b0;
        data_n    = 8'h00;
        rd_n      = 1'b0;
        to_n      = to_cnt;
        hdr_n     = hdr_idx;
        word_n    = word_idx;
        flushed_n = flushed_r;
        seq_n     = frame_seq;
        drop_n    = drop_cnt;
        tag_n     = tag_r;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                flushed_n = 1'b0;
                if (start_ok) begin
                    state_n = ST_REQ;
                    req_n   = 1'b1;
                    to_n    = '0;
                    tag_n   = stream_tag;
                end
            end
            ST_REQ: begin
                if (app_tx_ack) begin
                    state_n   = ST_HDR;
                    valid_n   = 1'b1;
                    hdr_n     = 3'd0;
                    flushed_n = fifo_flush;
                    data_n    = fifo_flush ? 8'h00 : hdr_byte(3'd0, MAGIC, tag_r, frame_seq, PW16);
                end else if (fifo_flush) begin
                    state_n = ST_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    state_n = ST_IDLE;
                    if (drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
                end else begin
                    req_n = 1'b1;
                    to_n  = to_cnt + 1'b1;
                end
            end
            ST_HDR: begin
                valid_n   = 1'b1;
                flushed_n = zero;
                if (hdr_idx == 3'd7) begin
                    state_n  = ST_DATA;
                    ser_load = 1'b1;
                    data_n   = ser_byte;
                    word_n   = '0;
                end else begin
                    hdr_n  = hdr_idx + 3'd1;
                    data_n = zero ? 8'h00 : hdr_byte(hdr_idx + 3'd1, MAGIC, tag_r, frame_seq, PW16);
                    rd_n   = (hdr_idx == 3'd5) && !zero;
                end
            end
            ST_DATA: begin
                flushed_n = zero;
                if (ser_word_end) begin
                    if (word_idx == LAST_WORD) begin
                        state_n = ST_DONE;
                    end else begin
                        valid_n  = 1'b1;
                        ser_load = 1'b1;
                        data_n   = ser_byte;
                        word_n   = word_idx + 12'd1;
                    end
                end else begin
                    valid_n   = 1'b1;
                    ser_shift = 1'b1;
                    data_n    = ser_byte;
                    rd_n      = ser_rd_slot && (word_idx != LAST_WORD) && !zero;
                end
            end
            ST_DONE: begin
                seq_n   = frame_seq + 16'd1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            to_cnt              <= '0;
            hdr_idx             <= '0;
            word_idx            <= '0;
            tag_r               <= '0;
            flushed_r           <= 1'b0;
            frame_seq           <= '0;
            drop_cnt            <= '0;
            app_tx_data_request <= 1'b0;
            app_tx_data_valid   <= 1'b0;
            app_tx_data         <= '0;
            fifo_rd_en          <= 1'b0;
        end else begin
            state               <= state_n;
            to_cnt              <= to_n;
            hdr_idx             <= hdr_n;
            word_idx            <= word_n;
            tag_r               <= tag_n;
            flushed_r           <= flushed_n;
            frame_seq           <= seq_n;
            drop_cnt            <= drop_n;
            app_tx_data_request <= req_n;
            app_tx_data_valid   <= valid_n;
            app_tx_data         <= data_n;
            fifo_rd_en          <= rd_n;
        end
    end

endmodule

// File: tb/tb_sig_eth_udp_packer.sv
// tb/tb_sig_eth_udp_packer.sv - directed self-checking bench for sig_eth_udp_packer
module tb_sig_eth_udp_packer;
    import sig_eth_udp_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  stream_tag;
    logic        fifo_flush;
    logic [31:0] fifo_rd_data = 32'h0;
    logic [11:0] fifo_rd_level;
    logic        fifo_rd_en;
    logic        udp_tx_ready;
    logic        app_tx_data_request;
    logic        app_tx_ack;
    logic [15:0] udp_data_length;
    logic        app_tx_data_valid;
    logic [7:0]  app_tx_data;
    logic [15:0] frame_seq;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int nbytes = 0;
    int rd_cnt = 0;
    logic [7:0]  byte_log [256];
    int          byte_cyc [256];
    logic [7:0]  exp_b [24];
    logic [2:0]  rp = 3'd0;
    logic [31:0] mem [8] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF01,
                             32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D, 32'h3A3B3C3D};

    sig_eth_udp_packer #(
        .PAYLOAD_WORDS (4),
        .LVL_W         (12),
        .ACK_TIMEOUT   (16),
        .MAGIC         (16'hA55A)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .stream_tag          (stream_tag),
        .fifo_flush          (fifo_flush),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_level       (fifo_rd_level),
        .fifo_rd_en          (fifo_rd_en),
        .udp_tx_ready        (udp_tx_ready),
        .app_tx_data_request (app_tx_data_request),
        .app_tx_ack          (app_tx_ack),
        .udp_data_length     (udp_data_length),
        .app_tx_data_valid   (app_tx_data_valid),
        .app_tx_data         (app_tx_data),
        .frame_seq           (frame_seq),
        .drop_cnt            (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Standard-mode FIFO: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (fifo_flush) begin
            rp <= 3'd0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rp];
            rp           <= rp + 3'd1;
        end
    end

    always @(negedge clk) begin
        if (app_tx_data_valid && nbytes < 256) begin
            byte_log[nbytes] <= app_tx_data;
            byte_cyc[nbytes] <= cyc;
            nbytes           <= nbytes + 1;
        end
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wait_bytes(input string tag, input int target);
        int k = 0;
        while (nbytes < target && k < 100) begin
            @(posedge clk);
            k++;
        end
        chk(tag, 32'(nbytes >= target), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!app_tx_data_request && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(app_tx_data_request), 32'd1);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    initial begin
        int base;
        int rd_base;
        int k;
        int req_cyc;
        logic seen;

        rst_n = 1'b0; enable = 1'b0; stream_tag = 2'b00; fifo_flush = 1'b0;
        fifo_rd_level = 12'd0; udp_tx_ready = 1'b0; app_tx_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(app_tx_data_request), 32'd0);
        chk("rst_valid", 32'(app_tx_data_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_data", 32'(app_tx_data), 32'd0);
        chk("rst_seq", 32'(frame_seq), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_len", 32'(udp_data_length), 32'd24);
        rst_n = 1'b1;

        // Level below payload size never requests; reaching it requests one cycle later
        @(negedge clk);
        enable = 1'b1; udp_tx_ready = 1'b1; stream_tag = TAG_AD; fifo_rd_level = 12'd3;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | app_tx_data_request;
        end
        chk("low_level_no_req", 32'(seen), 32'd0);
        base = nbytes; rd_base = rd_cnt;
        fifo_rd_level = 12'd4;
        @(negedge clk);
        chk("req_one_cycle", 32'(app_tx_data_request), 32'd1);
        repeat (2) @(negedge clk);
        chk("req_held", 32'(app_tx_data_request), 32'd1);
        app_tx_ack = 1'b1;
        @(negedge clk);
        app_tx_ack = 1'b0; fifo_rd_level = 12'd0;
        chk("req_after_ack", 32'(app_tx_data_request), 32'd0);
        chk("first_byte_valid", 32'(app_tx_data_valid), 32'd1);
        wait_bytes("a_bytes_done", base + 24);
        repeat (3) @(negedge clk);
        exp_b = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04,
                  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01};
        for (int i = 0; i < 24; i++) chk($sformatf("a_byte%0d", i), 32'(byte_log[base + i]), 32'(exp_b[i]));
        chk("a_contiguous", 32'(byte_cyc[base + 23] - byte_cyc[base]), 32'd23);
        chk("a_byte_count", 32'(nbytes - base), 32'd24);
        chk("a_rd_count", 32'(rd_cnt - rd_base), 32'd4);
        chk("a_seq", 32'(frame_seq), 32'd1);
        chk("a_len", 32'(udp_data_length), 32'd24);

        // Ack never comes: request held for the full timeout, then dropped and re-issued
        fifo_rd_level = 12'd4;
        wait_req("b_req_seen");
        k = 0;
        while (app_tx_data_request && k < 40) begin
            k++;
            @(negedge clk);
        end
        chk("b_req_cycles", 32'(k), 32'd16);
        chk("b_drop", 32'(drop_cnt), 32'd1);
        chk("b_seq_kept", 32'(frame_seq), 32'd1);
        @(negedge clk);
        chk("b_re_request", 32'(app_tx_data_request), 32'd1);
        fifo_flush = 1'b1; fifo_rd_level = 12'd0;
        @(negedge clk);
        fifo_flush = 1'b0;
        chk("b_flush_req_off", 32'(app_tx_data_request), 32'd0);
        chk("b_flush_no_drop", 32'(drop_cnt), 32'd1);

        // Flush while word 1 byte 1 is on the wire: length kept, rest zeroed, no further reads
        enable = 1'b0;
        pulse_flush();
        base = nbytes; rd_base = rd_cnt;
        stream_tag = TAG_HDMI; fifo_rd_level = 12'd4; enable = 1'b1;
        wait_req("c_req_seen");
        app_tx_ack = 1'b1;
        @(negedge clk);
        app_tx_ack = 1'b0; fifo_rd_level = 12'd0;
        repeat (13) @(negedge clk);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        wait_bytes("c_bytes_done", base + 24);
        repeat (3) @(negedge clk);
        exp_b = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04,
                  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 24; i++) chk($sformatf("c_byte%0d", i), 32'(byte_log[base + i]), 32'(exp_b[i]));
        chk("c_byte_count", 32'(nbytes - base), 32'd24);
        chk("c_contiguous", 32'(byte_cyc[base + 23] - byte_cyc[base]), 32'd23);
        chk("c_rd_count", 32'(rd_cnt - rd_base), 32'd2);
        chk("c_seq", 32'(frame_seq), 32'd2);

        // Back-to-back frames across the sequence wrap
        enable = 1'b0;
        pulse_flush();
        force dut.frame_seq = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.frame_seq;
        @(negedge clk);
        chk("d_seq_preset", 32'(frame_seq), 32'hFFFF);
        base = nbytes;
        stream_tag = TAG_AD; fifo_rd_level = 12'd8; enable = 1'b1;
        wait_req("d_req1_seen");
        app_tx_ack = 1'b1;
        @(negedge clk);
        app_tx_ack = 1'b0;
        wait_bytes("d_frame1_done", base + 24);
        wait_req("d_req2_seen");
        req_cyc = cyc;
        app_tx_ack = 1'b1;
        @(negedge clk);
        app_tx_ack = 1'b0; fifo_rd_level = 12'd0;
        wait_bytes("d_frame2_done", base + 48);
        repeat (3) @(negedge clk);
        chk("d_f1_seq_hi", 32'(byte_log[base + 4]), 32'hFF);
        chk("d_f1_seq_lo", 32'(byte_log[base + 5]), 32'hFF);
        chk("d_f1_word0", 32'(byte_log[base + 8]), 32'h11);
        chk("d_f2_seq_hi", 32'(byte_log[base + 28]), 32'h00);
        chk("d_f2_seq_lo", 32'(byte_log[base + 29]), 32'h00);
        chk("d_f2_word0", 32'(byte_log[base + 32]), 32'h0A);
        chk("d_f2_last", 32'(byte_log[base + 47]), 32'h3D);
        chk("d_gap_min2", 32'((req_cyc - byte_cyc[base + 23] - 1) >= 2), 32'd1);
        chk("d_seq_after", 32'(frame_seq), 32'd1);

        // Reset in the middle of the data phase
        enable = 1'b0;
        pulse_flush();
        fifo_rd_level = 12'd4; enable = 1'b1;
        wait_req("e_req_seen");
        app_tx_ack = 1'b1;
        @(negedge clk);
        app_tx_ack = 1'b0; fifo_rd_level = 12'd0;
        repeat (10) @(negedge clk);
        chk("e_pre_valid", 32'(app_tx_data_valid), 32'd1);
        chk("e_pre_rd_en", 32'(fifo_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("e_rst_valid", 32'(app_tx_data_valid), 32'd0);
        chk("e_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("e_rst_req", 32'(app_tx_data_request), 32'd0);
        chk("e_rst_data", 32'(app_tx_data), 32'd0);
        chk("e_rst_seq", 32'(frame_seq), 32'd0);
        chk("e_rst_drop", 32'(drop_cnt), 32'd0);
        chk("e_rst_len", 32'(udp_data_length), 32'd24);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | app_tx_data_request;
        end
        chk("e_idle_no_req", 32'(seen), 32'd0);
        fifo_rd_level = 12'd4;
        @(negedge clk);
        chk("e_req_after", 32'(app_tx_data_request), 32'd1);
        chk("e_seq_zero", 32'(frame_seq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
